// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------------------------
// sound_pkg: shared constants and types for the per-channel APU sequencer blocks.
//   FS_W          - frame-sequencer step width (8 steps)
//   LEN_STEP_MASK - bit n set when entering step n clocks the length counter
//   ENV_STEP      - step whose entry clocks the volume envelope
//   VOL_W/VOL_MAX - envelope volume width and saturation ceiling
// ---------------------------------------------------------------------------------------------
package sound_pkg;

  localparam int unsigned FS_W = 3;
  typedef logic [FS_W-1:0] fs_step_t;

  localparam logic [7:0] LEN_STEP_MASK = 8'b0101_0101;
  localparam fs_step_t   ENV_STEP      = 3'd7;

  localparam int unsigned VOL_W = 4;
  typedef logic [VOL_W-1:0] vol_t;
  localparam vol_t VOL_MAX = 4'd15;

  // True when entering `step` produces a length clock.
  function automatic logic is_len_step(input fs_step_t step);
    return LEN_STEP_MASK[step];
  endfunction

endpackage

// File: rtl/sound_length_ctr.sv
// ---------------------------------------------------------------------------------------------
// sound_length_ctr: channel length counter holding the remaining count as LEN_BITS+1 bits.
// Shared by square/noise channels (LEN_BITS=6) and the wave channel (LEN_BITS=8).
//   clk, rst    - system clock, synchronous active-high reset
//   load        - strobe: counter <- 2^LEN_BITS - load_data
//   load_data   - length register value
//   trigger     - strobe: suppresses the decrement; reloads 2^LEN_BITS if the count is 0
//   clock       - length clock strobe from the frame sequencer
//   enable      - length counting enabled (level)
//   expired     - combinational strobe: this cycle's decrement reaches 0
//   zero        - registered count is 0
// ---------------------------------------------------------------------------------------------
module sound_length_ctr #(
  parameter int unsigned LEN_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LEN_BITS-1:0] load_data,
  input  logic                trigger,
  input  logic                clock,
  input  logic                enable,
  output logic                expired,
  output logic                zero
);

  localparam int unsigned CW = LEN_BITS + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {LEN_BITS{1'b0}}};

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (load) begin
      cnt_d = FULL - {1'b0, load_data};
    end else if (clock && enable && !trigger && (cnt_q != '0)) begin
      cnt_d   = cnt_q - CW'(1);
      expired = (cnt_d == '0);
    end
    // A trigger applies to the value after any same-cycle load.
    if (trigger && (cnt_d == '0)) begin
      cnt_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sound_channel_ctrl.sv
// ---------------------------------------------------------------------------------------------
// sound_channel_ctrl: per-channel APU sequencer feeding the channel mixer.
// Frame sequencer (512 Hz steps), length counter (256 Hz), volume envelope (64 Hz), trigger and
// DAC-off handling. All outputs are registered.
//   clk, rst      - system clock, synchronous active-high reset
//   tick_512      - 512 Hz strobe advancing the frame sequencer
//   trigger       - channel (re)start strobe
//   length_load   - strobe loading the length counter from length_data
//   length_data   - length register value
//   length_en     - length counting enabled (level)
//   env_init_vol  - initial envelope volume
//   env_dir       - envelope direction, 1 = increase
//   env_period    - envelope period, 0 = frozen
//   ch_enable     - channel active (mixer enable)
//   target_vol    - current envelope volume (mixer target_vol)
//   fs_step       - current frame-sequencer step
// Build option: define SOUND_ENV_LATCH_EN to latch the envelope once it saturates, until the
// next trigger or reset.
// ---------------------------------------------------------------------------------------------
module sound_channel_ctrl
  import sound_pkg::*;
#(
  parameter int unsigned LEN_BITS = 6,
  parameter int unsigned PER_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_512,
  input  logic                trigger,
  input  logic                length_load,
  input  logic [LEN_BITS-1:0] length_data,
  input  logic                length_en,
  input  logic [VOL_W-1:0]    env_init_vol,
  input  logic                env_dir,
  input  logic [PER_BITS-1:0] env_period,
  output logic                ch_enable,
  output logic [VOL_W-1:0]    target_vol,
  output logic [FS_W-1:0]     fs_step
);

  fs_step_t            fs_q, fs_d, fs_next;
  logic                ch_en_q, ch_en_d;
  vol_t                vol_q, vol_d;
  logic [PER_BITS-1:0] timer_q, timer_d;

  logic len_clk, env_clk, dac_on;
  logic len_expired, len_zero;
  logic env_run;

  // Clocks fire in the tick cycle, keyed on the step being entered.
  assign fs_next = fs_q + FS_W'(1);
  assign len_clk = tick_512 && is_len_step(fs_next);
  assign env_clk = tick_512 && (fs_next == ENV_STEP);
  assign dac_on  = (env_init_vol != '0) || env_dir;

  sound_length_ctr #(
    .LEN_BITS (LEN_BITS)
  ) u_length (
    .clk       (clk),
    .rst       (rst),
    .load      (length_load),
    .load_data (length_data),
    .trigger   (trigger),
    .clock     (len_clk),
    .enable    (length_en),
    .expired   (len_expired),
    .zero      (len_zero)
  );

`ifdef SOUND_ENV_LATCH_EN
  logic stopped_q, stopped_d;
  assign env_run = !stopped_q;
`else
  assign env_run = 1'b1;
`endif

  // Frame sequencer: advances on every tick, independent of trigger.
  always_comb begin
    fs_d = tick_512 ? fs_next : fs_q;
  end

  // Envelope: trigger reload wins over any envelope clock in the same cycle.
  always_comb begin
    vol_d   = vol_q;
    timer_d = timer_q;
`ifdef SOUND_ENV_LATCH_EN
    stopped_d = stopped_q;
`endif
    if (trigger) begin
      vol_d   = env_init_vol;
      timer_d = env_period;
`ifdef SOUND_ENV_LATCH_EN
      stopped_d = 1'b0;
`endif
    end else if (env_clk && (env_period != '0) && env_run) begin
      if (timer_q > PER_BITS'(1)) begin
        timer_d = timer_q - PER_BITS'(1);
      end else begin
        timer_d = env_period;
        if (env_dir && (vol_q != VOL_MAX)) begin
          vol_d = vol_q + VOL_W'(1);
        end else if (!env_dir && (vol_q != '0)) begin
          vol_d = vol_q - VOL_W'(1);
        end
`ifdef SOUND_ENV_LATCH_EN
        stopped_d = env_dir ? (vol_d == VOL_MAX) : (vol_d == '0);
`endif
      end
    end
  end

  // Channel enable: DAC-off has the last word, then trigger, then length expiry.
  always_comb begin
    ch_en_d = ch_en_q;
    // An empty length counter can never back an active channel unless this cycle retriggers.
    if (len_expired || len_zero) begin
      ch_en_d = 1'b0;
    end
    if (trigger) begin
      ch_en_d = dac_on;
    end
    if (!dac_on) begin
      ch_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q    <= '0;
      ch_en_q <= 1'b0;
      vol_q   <= '0;
      timer_q <= '0;
`ifdef SOUND_ENV_LATCH_EN
      stopped_q <= 1'b0;
`endif
    end else begin
      fs_q    <= fs_d;
      ch_en_q <= ch_en_d;
      vol_q   <= vol_d;
      timer_q <= timer_d;
`ifdef SOUND_ENV_LATCH_EN
      stopped_q <= stopped_d;
`endif
    end
  end

  assign ch_enable  = ch_en_q;
  assign target_vol = vol_q;
  assign fs_step    = fs_q;

endmodule
